// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and mode constants for the PWM ramp sequencer
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_RAMP   = 2'd3
  } state_t;

  localparam logic SEL_960HZ        = 1'b0;
  localparam logic SEL_50HZ         = 1'b1;
  localparam int   DUTY_MAX_DEFAULT = 100;

endpackage

// File: rtl/pwm_step_div.sv
// rtl/pwm_step_div.sv - counts PWM period ticks and pulses step on every PERIODS_PER_STEP-th one
module pwm_step_div #(
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic clear,
  output logic step
);

  localparam int CW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIODS_PER_STEP - 1);

  logic [CW-1:0] count;

  // clear outranks a coincident tick so that tick is never counted
  assign step = ena & tick & ~clear & (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (clear) begin
        count <= '0;
      end else if (tick) begin
        count <= step ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// rtl/pwm_ramp_sequencer.sv - period-aligned duty ramp with drain-before-mode-switch sequencing
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int WIDTH            = 7,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4,
  parameter int DUTY_MAX         = DUTY_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             period_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_duty,
  input  logic             cmd_sel,
  output logic [WIDTH-1:0] duty_o,
  output logic             sel_o,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] DMAX_W = (WIDTH + 1)'(DUTY_MAX);

  state_t           state;
  logic [WIDTH-1:0] target;
  logic             tgt_sel;
  logic             accept;
  logic             div_clear;
  logic             step;

  logic [WIDTH:0]   duty_w;
  logic [WIDTH:0]   tgt_w;
  logic [WIDTH:0]   cmd_w;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   down_gap;
  logic [WIDTH-1:0] cmd_clamped;
  logic [WIDTH-1:0] drain_next;
  logic [WIDTH-1:0] ramp_next;

  assign cmd_ready = ena & (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign div_clear = accept | (ena & period_tick & (state == ST_SWITCH));

  // One extra bit of headroom keeps the step arithmetic from wrapping at either end
  assign duty_w      = {1'b0, duty_o};
  assign tgt_w       = {1'b0, target};
  assign cmd_w       = {1'b0, cmd_duty};
  assign up_sum      = duty_w + STEP_W;
  assign down_gap    = duty_w - tgt_w;
  assign cmd_clamped = (cmd_w > DMAX_W) ? DMAX_W[WIDTH-1:0] : cmd_duty;
  assign drain_next  = (duty_w > STEP_W) ? (duty_o - STEP_W[WIDTH-1:0]) : '0;
  assign ramp_next   = (duty_w < tgt_w)
                     ? ((up_sum >= tgt_w) ? target : up_sum[WIDTH-1:0])
                     : ((down_gap <= STEP_W) ? target : (duty_o - STEP_W[WIDTH-1:0]));

  pwm_step_div #(
    .PERIODS_PER_STEP(PERIODS_PER_STEP)
  ) u_step_div (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (period_tick),
    .clear (div_clear),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      duty_o  <= '0;
      sel_o   <= SEL_960HZ;
      target  <= '0;
      tgt_sel <= SEL_960HZ;
      done    <= 1'b0;
    end else if (!ena) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            target  <= cmd_clamped;
            tgt_sel <= cmd_sel;
            if (cmd_sel != sel_o) begin
              state <= (duty_o != '0) ? ST_DRAIN : ST_SWITCH;
            end else if (duty_o != cmd_clamped) begin
              state <= ST_RAMP;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (step) begin
            duty_o <= drain_next;
            if (drain_next == '0) begin
              state <= ST_SWITCH;
            end
          end
        end
        // Mode changes only at a period boundary with the output already at zero
        ST_SWITCH: begin
          if (period_tick) begin
            sel_o <= tgt_sel;
            if (target != '0) begin
              state <= ST_RAMP;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        ST_RAMP: begin
          if (step) begin
            duty_o <= ramp_next;
            if (ramp_next == target) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb/tb_pwm_ramp_sequencer.sv - scoreboard bench: expected duty/sel/done events queued, monitor compares
module tb_pwm_ramp_sequencer;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       period_tick;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_duty;
  logic       cmd_sel;
  logic [6:0] duty_o;
  logic       sel_o;
  logic       busy;
  logic       done;

  pwm_ramp_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .period_tick (period_tick),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .cmd_sel     (cmd_sel),
    .duty_o      (duty_o),
    .sel_o       (sel_o),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  localparam int EV_CHANGE = 0;
  localparam int EV_DONE   = 1;

  typedef struct {
    int kind;
    int duty;
    int sel;
    int tick;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         tick_no   = 0;
  int         max_duty  = 0;
  bit         mon_en    = 1'b0;
  logic [6:0] prev_duty = '0;
  logic       prev_sel  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int d, input int s, input int t);
    ev_t e;
    e.kind = kind;
    e.duty = d;
    e.sel  = s;
    e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d duty=%0d sel=%0d tick=%0d, none expected",
               kind, duty_o, sel_o, tick_no);
    end else begin
      mon_e = exp_q.pop_front();
      if (mon_e.kind != kind || mon_e.duty != int'(duty_o) || mon_e.sel != int'(sel_o) ||
          (mon_e.tick >= 0 && mon_e.tick != tick_no)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d duty=%0d sel=%0d tick=%0d expected kind=%0d duty=%0d sel=%0d tick=%0d",
                 kind, duty_o, sel_o, tick_no, mon_e.kind, mon_e.duty, mon_e.sel, mon_e.tick);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (duty_o !== prev_duty || sel_o !== prev_sel) begin
        observe(EV_CHANGE);
        prev_duty = duty_o;
        prev_sel  = sel_o;
      end
      if (done !== 1'b0) observe(EV_DONE);
      if (int'(duty_o) > max_duty) max_duty = int'(duty_o);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n, input bit counted);
    repeat (n) begin
      period_tick = 1'b1;
      if (counted) tick_no++;
      cycle();
      period_tick = 1'b0;
      repeat (3) cycle();
    end
  endtask

  task automatic send_cmd(input int d, input logic s, input bit with_tick);
    cmd_valid = 1'b1;
    cmd_duty  = d[6:0];
    cmd_sel   = s;
    check("cmd_ready_at_accept", int'(cmd_ready), 1);
    tick_no = 0;
    if (with_tick) begin
      period_tick = 1'b1;
      tick_no     = 1;
    end
    cycle();
    cmd_valid   = 1'b0;
    period_tick = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    ena         = 1'b1;
    period_tick = 1'b0;
    cmd_valid   = 1'b0;
    cmd_duty    = '0;
    cmd_sel     = SEL_960HZ;
    #2;
    mon_en = 1'b1;

    // reset values held across ticks
    cycle();
    do_ticks(10, 1'b0);
    check("reset_duty", int'(duty_o), 0);
    check("reset_sel", int'(sel_o), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    cycle();

    // ramp 0 -> 10, one step per 4 ticks
    for (int k = 1; k <= 10; k++) push_ev(EV_CHANGE, k, 0, 4 * k);
    push_ev(EV_DONE, 10, 0, 40);
    send_cmd(10, SEL_960HZ, 1'b0);
    check("busy_in_ramp", int'(busy), 1);
    do_ticks(44, 1'b1);
    check("idle_after_ramp", int'(busy), 0);

    // target 120 clamps to 100
    for (int k = 11; k <= 100; k++) push_ev(EV_CHANGE, k, 0, 4 * (k - 10));
    push_ev(EV_DONE, 100, 0, 360);
    send_cmd(120, SEL_960HZ, 1'b0);
    do_ticks(365, 1'b1);

    // ramp down 100 -> 10
    for (int k = 99; k >= 10; k--) push_ev(EV_CHANGE, k, 0, 4 * (100 - k));
    push_ev(EV_DONE, 10, 0, 360);
    send_cmd(10, SEL_960HZ, 1'b0);
    do_ticks(362, 1'b1);

    // mode change: drain to 0, switch on next tick, ramp to 6
    for (int k = 9; k >= 0; k--) push_ev(EV_CHANGE, k, 0, 4 * (10 - k));
    push_ev(EV_CHANGE, 0, 1, 41);
    for (int k = 1; k <= 6; k++) push_ev(EV_CHANGE, k, 1, 41 + 4 * k);
    push_ev(EV_DONE, 6, 1, 65);
    send_cmd(6, SEL_50HZ, 1'b0);
    do_ticks(68, 1'b1);

    // coincident tick not counted; command during ramp ignored
    push_ev(EV_CHANGE, 7, 1, 5);
    push_ev(EV_CHANGE, 8, 1, 9);
    push_ev(EV_CHANGE, 9, 1, 13);
    push_ev(EV_DONE, 9, 1, 13);
    send_cmd(9, SEL_50HZ, 1'b1);
    do_ticks(2, 1'b1);
    cmd_valid = 1'b1;
    cmd_duty  = 7'd50;
    cmd_sel   = SEL_960HZ;
    check("ready_in_ramp", int'(cmd_ready), 0);
    repeat (3) cycle();
    cmd_valid = 1'b0;
    do_ticks(10, 1'b1);
    do_ticks(8, 1'b1);
    check("idle_after_ignored_cmd", int'(busy), 0);

    // ena low freezes duty and divider mid-ramp
    push_ev(EV_CHANGE, 10, 1, 4);
    push_ev(EV_CHANGE, 11, 1, 8);
    send_cmd(12, SEL_50HZ, 1'b0);
    do_ticks(9, 1'b1);
    ena = 1'b0;
    do_ticks(20, 1'b0);
    check("frozen_duty", int'(duty_o), 11);
    check("frozen_ready", int'(cmd_ready), 0);
    check("frozen_done", int'(done), 0);
    check("frozen_busy", int'(busy), 1);
    ena = 1'b1;
    push_ev(EV_CHANGE, 12, 1, 12);
    push_ev(EV_DONE, 12, 1, 12);
    do_ticks(3, 1'b1);

    // async reset mid-ramp at duty 5
    push_ev(EV_CHANGE, 0, 0, -1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    for (int k = 1; k <= 5; k++) push_ev(EV_CHANGE, k, 0, 4 * k);
    send_cmd(8, SEL_960HZ, 1'b0);
    do_ticks(21, 1'b1);
    check("pre_reset_duty", int'(duty_o), 5);
    push_ev(EV_CHANGE, 0, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_duty", int'(duty_o), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_ready", int'(cmd_ready), 1);
    repeat (3) cycle();
    rst_n = 1'b1;
    do_ticks(10, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    check("max_duty", max_duty, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
